// File: rtl/counter_overflow_capture_pkg.sv
// Shared definitions for counter_overflow_capture: direction codes and the
// layout of one queued wrap event {dir, ts}.
package counter_overflow_capture_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Timestamp width of the default build; the entry struct uses it
    localparam int DEF_TS_W = 16;

    // One event entry as stored in the FIFO, direction in the MSB
    typedef struct packed {
        logic                dir;
        logic [DEF_TS_W-1:0] ts;
    } evt_entry_t;

    // Width of a packed {dir, ts} entry for an arbitrary timestamp width
    function automatic int evt_entry_width(input int ts_w);
        return ts_w + 1;
    endfunction

endpackage

// File: rtl/counter_overflow_capture_if.sv
// Event drain handshake: producer (master) presents the FIFO head,
// consumer (slave) accepts it with evt_ready.
interface counter_overflow_capture_if #(
    parameter int TS_W = 16
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic            evt_dir;
    logic [TS_W-1:0] evt_ts;

    modport master (output evt_valid, output evt_dir, output evt_ts, input evt_ready);
    modport slave  (input evt_valid, input evt_dir, input evt_ts, output evt_ready);
endinterface

// File: rtl/counter_overflow_capture_fifo.sv
// ovf_event_fifo: first-word-fall-through FIFO with a registered head.
// The head register only changes when a new entry becomes the head, so the
// outputs keep their last value while the FIFO is empty.
module ovf_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o = (cnt_q == {CNT_W{1'b0}});
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign dout_o  = head_q;

    // Next-state pointers, occupancy and head; a full FIFO still accepts a push when popping
    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        head_d    = head_q;
        if (clear_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            cnt_d = cnt_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
            if (cnt_d == {CNT_W{1'b0}}) begin
                head_d = head_q;
            end else if (do_push_s && (rd_ptr_d == wr_ptr_q)) begin
                head_d = din_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Register pointers, occupancy, head and storage
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            head_q   <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            if (do_push_s && !clear_i) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end
endmodule

// File: rtl/counter_overflow_capture.sv
// counter_overflow_capture: watches counter_8bit, counts wrap events into a
// signed epoch and queues {direction, timestamp} per event.
// Optional build macro OVF_CAP_STATS_EN enables the saturating evt_total counter.
module counter_overflow_capture
    import counter_overflow_capture_pkg::*;
#(
    parameter int EPOCH_W    = 8,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic [7:0]               count_i,
    input  logic                     overflow_i,
    input  logic                     up_down_i,
    output logic [EPOCH_W+8-1:0]     ext_count_o,
    output logic                     drop_o,
    output logic [15:0]              evt_total_o,
    counter_overflow_capture_if.master evt_if
);
    localparam int ENTRY_W = evt_entry_width(TS_W);

    logic [TS_W-1:0]    ts_q;
    logic               ov_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic               drop_q;
    logic               evt_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic [ENTRY_W-1:0] head_s;

    // Overflow already high after reset is masked by ov_q resetting to 1
    assign evt_s = overflow_i & ~ov_q;
    assign pop_s = evt_if.evt_valid & evt_if.evt_ready;

    assign ext_count_o      = {epoch_q, count_i};
    assign drop_o           = drop_q;
    assign evt_if.evt_valid = ~empty_s;
    assign evt_if.evt_dir   = head_s[ENTRY_W-1];
    assign evt_if.evt_ts    = head_s[TS_W-1:0];

    ovf_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .push_i  (evt_s),
        .pop_i   (evt_if.evt_ready),
        .din_i   ({up_down_i, ts_q}),
        .dout_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Timestamp, edge history, wrap epoch and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q    <= {TS_W{1'b0}};
            ov_q    <= 1'b1;
            epoch_q <= {EPOCH_W{1'b0}};
            drop_q  <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            ov_q <= overflow_i;
            if (clear_i) begin
                epoch_q <= {EPOCH_W{1'b0}};
                drop_q  <= 1'b0;
            end else begin
                if (evt_s) begin
                    if (up_down_i == DIR_UP) begin
                        epoch_q <= epoch_q + EPOCH_W'(1);
                    end else begin
                        epoch_q <= epoch_q - EPOCH_W'(1);
                    end
                end
                // A full FIFO without a pop this cycle loses the new entry
                if (evt_s && full_s && !pop_s) begin
                    drop_q <= 1'b1;
                end
            end
        end
    end

`ifdef OVF_CAP_STATS_EN
    logic [15:0] total_q;

    // Saturating count of every detected event, including dropped and cleared ones
    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= 16'd0;
        end else if (evt_s && (total_q != 16'hFFFF)) begin
            total_q <= total_q + 16'd1;
        end else begin
            total_q <= total_q;
        end
    end

    assign evt_total_o = total_q;
`else
    assign evt_total_o = 16'd0;
`endif
endmodule

// File: tb/tb_counter_overflow_capture.sv
// Directed bench for counter_overflow_capture: expected FIFO entries are queued
// when an event is issued and checked by a monitor when the DUT hands them out.
module tb_counter_overflow_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [7:0]  count;
    logic        overflow;
    logic        up_down;
    logic [15:0] ext_count;
    logic        drop;
    logic [15:0] evt_total;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] tb_ts    = 16'd0;
    int          exp_total = 0;
    logic [16:0] exp_q [$];

    counter_overflow_capture_if #(.TS_W(16)) evt_if ();

    counter_overflow_capture #(
        .EPOCH_W    (8),
        .TS_W       (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .count_i     (count),
        .overflow_i  (overflow),
        .up_down_i   (up_down),
        .ext_count_o (ext_count),
        .drop_o      (drop),
        .evt_total_o (evt_total),
        .evt_if      (evt_if)
    );

    always #5 clk = ~clk;

    // Reference free-running timestamp
    always @(posedge clk) begin
        if (rst) tb_ts <= 16'd0;
        else     tb_ts <= tb_ts + 16'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {15'd0, evt_if.evt_dir, evt_if.evt_ts}, 32'hFFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("pop_entry", {15'd0, evt_if.evt_dir, evt_if.evt_ts}, {15'd0, e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Rising overflow edge this cycle; optionally expect the entry to be kept
    task automatic fire(input logic dir, input bit keep);
        overflow = 1'b1;
        up_down  = dir;
        exp_total++;
        if (keep) exp_q.push_back({dir, tb_ts});
        step();
        overflow = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; count = 8'h5A; overflow = 1'b1; up_down = 1'b1;
        evt_if.evt_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        // Overflow held high across reset release is not an event
        repeat (3) step();
        chk("rst_valid", {31'd0, evt_if.evt_valid}, 32'd0);
        chk("rst_ext_count", {16'd0, ext_count}, 32'h0000_005A);
        chk("rst_drop", {31'd0, drop}, 32'd0);
        chk("rst_head", {15'd0, evt_if.evt_dir, evt_if.evt_ts}, 32'd0);
        overflow = 1'b0;
        step();
        fire(1'b1, 1'b1);
        chk("t1_ext_count", {16'd0, ext_count}, 32'h0000_015A);
        chk("t1_valid", {31'd0, evt_if.evt_valid}, 32'd1);
        chk("t1_dir", {31'd0, evt_if.evt_dir}, 32'd1);
        evt_if.evt_ready = 1'b1; step(); evt_if.evt_ready = 1'b0;

        // Up wrap at ts=20 held high for 5 cycles
        for (int i = 0; i < 100 && tb_ts != 16'd20; i++) step();
        chk("t2_ts_reached", {16'd0, tb_ts}, 32'd20);
        overflow = 1'b1; up_down = 1'b1;
        exp_total++;
        exp_q.push_back({1'b1, tb_ts});
        step();
        chk("t2_valid", {31'd0, evt_if.evt_valid}, 32'd1);
        chk("t2_ts", {16'd0, evt_if.evt_ts}, 32'd20);
        repeat (4) step();
        overflow = 1'b0;
        evt_if.evt_ready = 1'b1; step(); evt_if.evt_ready = 1'b0;
        chk("t2_single_entry", {31'd0, evt_if.evt_valid}, 32'd0);
        chk("t2_epoch", {24'd0, ext_count[15:8]}, 32'h02);

        // Epoch wraps both ways
        clear = 1'b1; step(); clear = 1'b0;
        chk("t3_clear_epoch", {24'd0, ext_count[15:8]}, 32'h00);
        step();
        count = 8'h00;
        fire(1'b0, 1'b1);
        chk("t3_down_wrap", {16'd0, ext_count}, 32'h0000_FF00);
        step();
        fire(1'b1, 1'b1);
        chk("t3_up_wrap", {24'd0, ext_count[15:8]}, 32'h00);
        evt_if.evt_ready = 1'b1; repeat (2) step(); evt_if.evt_ready = 1'b0;
        chk("t3_drained", {31'd0, evt_if.evt_valid}, 32'd0);

        // Five events into a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            fire(i[0], i < 4);
            step();
        end
        chk("t4_drop", {31'd0, drop}, 32'd1);
        chk("t4_valid", {31'd0, evt_if.evt_valid}, 32'd1);
        evt_if.evt_ready = 1'b1; repeat (4) step(); evt_if.evt_ready = 1'b0;
        chk("t4_empty", {31'd0, evt_if.evt_valid}, 32'd0);
        chk("t4_drop_sticky", {31'd0, drop}, 32'd1);

        // Full FIFO with push and pop in the same cycle
        clear = 1'b1; step(); clear = 1'b0;
        chk("t5_clear_drop", {31'd0, drop}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            fire(~i[0], 1'b1);
            step();
        end
        evt_if.evt_ready = 1'b1;
        fire(1'b1, 1'b1);
        evt_if.evt_ready = 1'b0;
        chk("t5_no_drop", {31'd0, drop}, 32'd0);
        evt_if.evt_ready = 1'b1;
        repeat (3) step();
        chk("t5_occupancy4", {31'd0, evt_if.evt_valid}, 32'd1);
        step();
        evt_if.evt_ready = 1'b0;
        chk("t5_occupancy0", {31'd0, evt_if.evt_valid}, 32'd0);

        // Clear in the same cycle as an event
        fire(1'b1, 1'b0);
        step();
        clear = 1'b1;
        fire(1'b1, 1'b0);
        clear = 1'b0;
        chk("t6_valid", {31'd0, evt_if.evt_valid}, 32'd0);
        chk("t6_epoch", {24'd0, ext_count[15:8]}, 32'h00);
        chk("t6_drop", {31'd0, drop}, 32'd0);
        step();
        fire(1'b0, 1'b1);
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        evt_if.evt_ready = 1'b0;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
`ifdef OVF_CAP_STATS_EN
        chk("evt_total", {16'd0, evt_total}, exp_total);
`else
        chk("evt_total", {16'd0, evt_total}, 32'd0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
